access_port_arbiter: RTL

- Shares one network access port among NUM_REQ local requesters (cores/DMA) using round-robin arbitration.
- Sequences each transaction onto the port: one-cycle read/write issue, then waits for readReady on reads and returns data to the winning requester.
- Sits between requesters and one access port (port0..port3) of the mesh network top; one instance per port used.

---
 rtl/access_port_arbiter_pkg.sv | 16 +
 rtl/access_port_arbiter_rr_arbiter.sv | 32 +++
 rtl/access_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/access_port_arbiter_pkg.sv
// Shared widths and FSM state encoding for the access port arbiter.
package access_port_arbiter_pkg;

    localparam int NETWORK_ADDRESS_WIDTH    = 4;
    localparam int CACHE_BANK_ADDRESS_WIDTH = 4;
    localparam int ADDR_W                   = NETWORK_ADDRESS_WIDTH + CACHE_BANK_ADDRESS_WIDTH;
    localparam int DATA_WIDTH               = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/access_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        // k = NUM_REQ lands back on ptr itself, so the last winner has lowest priority.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/access_port_arbiter.sv
// Round-robin sharing of one mesh access port; one transaction in flight at a time.
// Optional read timeout in WAIT enabled by defining ACCESS_ARB_TIMEOUT_EN.
module access_port_arbiter
    import access_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_err,
    output logic                          busy,
    output logic [ADDR_W-1:0]             net_destinationAddressOut,
    output logic                          net_readOut,
    output logic                          net_writeOut,
    output logic [DATA_WIDTH-1:0]         net_dataOut,
    input  logic                          net_readReadyIn,
    input  logic [DATA_WIDTH-1:0]         net_dataIn
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || IDX_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("access_port_arbiter: illegal parameter combination");
    end

    arb_state_e                state_q, state_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d, idx_q, idx_d;
    logic                      write_q, write_d;
    logic [ADDR_W-1:0]         net_addr_q, net_addr_d;
    logic [DATA_WIDTH-1:0]     net_data_q, net_data_d;
    logic                      net_rd_q, net_rd_d, net_wr_q, net_wr_d;
    logic [NUM_REQ-1:0]        resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]     resp_data_q, resp_data_d;
    logic                      resp_err_q, resp_err_d;
    logic [NUM_REQ-1:0]        gnt;
    logic [IDX_W-1:0]          gnt_idx;
    logic                      timeout;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (state_q == ARB_IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

`ifdef ACCESS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counter sits at zero outside WAIT, so it is cleared on every WAIT entry.
    assign wait_cnt_d = (state_q == ARB_WAIT) ? wait_cnt_q + 1'b1 : '0;
    assign timeout    = (state_q == ARB_WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wait_cnt_q <= '0;
        else       wait_cnt_q <= wait_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        write_d      = write_q;
        net_addr_d   = '0;
        net_data_d   = '0;
        net_rd_d     = 1'b0;
        net_wr_d     = 1'b0;
        resp_valid_d = '0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            ARB_IDLE: if (|gnt) begin
                state_d    = ARB_ISSUE;
                ptr_d      = gnt_idx;
                idx_d      = gnt_idx;
                write_d    = req_write[gnt_idx];
                net_addr_d = req_addr[gnt_idx*ADDR_W +: ADDR_W];
                net_data_d = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                net_rd_d   = ~req_write[gnt_idx];
                net_wr_d   = req_write[gnt_idx];
            end
            ARB_ISSUE: begin
                state_d = write_q ? ARB_DONE : ARB_WAIT;
                if (write_q) resp_valid_d = NUM_REQ'(1) << idx_q;
            end
            ARB_WAIT: begin
                // readReady takes precedence over a coincident timeout.
                if (net_readReadyIn) begin
                    state_d      = ARB_DONE;
                    resp_valid_d = NUM_REQ'(1) << idx_q;
                    resp_data_d  = net_dataIn;
                end else if (timeout) begin
                    state_d      = ARB_DONE;
                    resp_valid_d = NUM_REQ'(1) << idx_q;
                    resp_err_d   = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            ptr_q        <= IDX_W'(NUM_REQ - 1);
            idx_q        <= '0;
            write_q      <= 1'b0;
            net_addr_q   <= '0;
            net_data_q   <= '0;
            net_rd_q     <= 1'b0;
            net_wr_q     <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            write_q      <= write_d;
            net_addr_q   <= net_addr_d;
            net_data_q   <= net_data_d;
            net_rd_q     <= net_rd_d;
            net_wr_q     <= net_wr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready                 = gnt;
    assign busy                      = (state_q != ARB_IDLE);
    assign net_destinationAddressOut = net_addr_q;
    assign net_dataOut               = net_data_q;
    assign net_readOut               = net_rd_q;
    assign net_writeOut              = net_wr_q;
    assign resp_valid                = resp_valid_q;
    assign resp_data                 = resp_data_q;
    assign resp_err                  = resp_err_q;

endmodule
